// File: rtl/csr_access_ctrl_if.sv
// Request/response bundle between the CSR access sequencer and its two requesters
// (decode-stage CSR instruction port and trap/mret port).
interface csr_access_ctrl_if;
    logic        ins_valid;
    logic        ins_ready;
    logic [2:0]  ins_funct3;
    logic [11:0] ins_addr;
    logic [31:0] ins_src;
    logic [4:0]  ins_zimm;
    logic        ins_src_zero;

    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_illegal;

    logic        trap_valid;
    logic        trap_ready;
    logic        trap_is_mret;
    logic [31:0] trap_cause;
    logic [31:0] trap_pc;

    logic        redir_valid;
    logic [31:0] redir_pc;

    modport master (
        output ins_valid, ins_funct3, ins_addr, ins_src, ins_zimm, ins_src_zero,
        input  ins_ready, rsp_valid, rsp_rdata, rsp_illegal,
        output trap_valid, trap_is_mret, trap_cause, trap_pc,
        input  trap_ready, redir_valid, redir_pc
    );

    modport slave (
        input  ins_valid, ins_funct3, ins_addr, ins_src, ins_zimm, ins_src_zero,
        output ins_ready, rsp_valid, rsp_rdata, rsp_illegal,
        input  trap_valid, trap_is_mret, trap_cause, trap_pc,
        output trap_ready, redir_valid, redir_pc
    );
endinterface

// File: rtl/csr_access_ctrl.sv
// Sequences CSR instruction read-modify-write, trap entry and mret against the CSR file.
// Optional `CSR_COUNTER_EN adds an internal 64-bit mcycle at 0xB00/0xB80 (RO aliases 0xC00/0xC80).
//
// state   | meaning
// IDLE    | waiting for a request; trap port has priority
// RD      | read old CSR value (file or counter)
// WR      | respond with old value, write new value if legal
// T_EPC   | trap entry: write mepc
// T_CAUSE | trap entry: write mcause
// T_VEC   | trap entry: read mtvec, redirect fetch
// M_EPC   | mret: read mepc, redirect fetch
module csr_access_ctrl #(
    parameter logic [11:0] MTVEC_ADDR  = 12'h305,
    parameter logic [11:0] MEPC_ADDR   = 12'h341,
    parameter logic [11:0] MCAUSE_ADDR = 12'h342
) (
    input  logic              clk,
    input  logic              rstn,
    csr_access_ctrl_if.slave  bus,
    output logic              csr_r_en,
    output logic [11:0]       csr_addr,
    input  logic [31:0]       csr_rdata,
    output logic              csr_w_en,
    output logic [11:0]       csr_w_addr,
    output logic [31:0]       csr_w_data
);

    typedef enum logic [2:0] {
        IDLE, RD, WR, T_EPC, T_CAUSE, T_VEC, M_EPC
    } state_t;

    state_t state, state_nxt;

    logic [2:0]  funct3_q;
    logic [11:0] addr_q;
    logic [31:0] src_q;
    logic [4:0]  zimm_q;
    logic        src_zero_q;
    logic [31:0] cause_q;
    logic [31:2] pc_q;
    logic [31:0] old_q;

    logic        ins_hs, trap_hs;
    logic        bad_funct3, wr_req, illegal, wr_ok;
    logic [31:0] operand, new_val, rd_val;
    logic        cnt_rd;
    logic [31:0] cnt_val;

    assign bus.ins_ready  = rstn && (state == IDLE) && !bus.trap_valid;
    assign bus.trap_ready = rstn && (state == IDLE);
    assign ins_hs  = bus.ins_valid && bus.ins_ready;
    assign trap_hs = bus.trap_valid && bus.trap_ready;

    assign bad_funct3 = (funct3_q[1:0] == 2'b00);
    assign operand    = funct3_q[2] ? {27'b0, zimm_q} : src_q;
    // RS/RC with a zero operand are pure reads, so they never trip the read-only check
    assign wr_req     = !bad_funct3 &&
                        ((funct3_q[1:0] == 2'b01) || (funct3_q[2] ? (zimm_q != 5'd0) : !src_zero_q));
    assign illegal    = bad_funct3 || (wr_req && (addr_q[11:10] == 2'b11));
    assign wr_ok      = wr_req && !illegal;

    always_comb begin
        new_val = old_q;
        case (funct3_q[1:0])
            2'b01:   new_val = operand;
            2'b10:   new_val = old_q | operand;
            2'b11:   new_val = old_q & ~operand;
            default: new_val = old_q;
        endcase
    end

`ifdef CSR_COUNTER_EN
    logic [63:0] mcycle;
    logic        cnt_hi, cnt_wr_lo, cnt_wr_hi;

    assign cnt_hi    = (addr_q == 12'hB80) || (addr_q == 12'hC80);
    assign cnt_rd    = cnt_hi || (addr_q == 12'hB00) || (addr_q == 12'hC00);
    assign cnt_val   = cnt_hi ? mcycle[63:32] : mcycle[31:0];
    assign cnt_wr_lo = rstn && (state == WR) && wr_ok && (addr_q == 12'hB00);
    assign cnt_wr_hi = rstn && (state == WR) && wr_ok && (addr_q == 12'hB80);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            mcycle <= '0;
        end else if (cnt_wr_lo) begin
            mcycle[31:0] <= new_val;
        end else if (cnt_wr_hi) begin
            mcycle[63:32] <= new_val;
        end else begin
            mcycle <= mcycle + 64'd1;
        end
    end
`else
    assign cnt_rd  = 1'b0;
    assign cnt_val = '0;
`endif

    assign rd_val = cnt_rd ? cnt_val : csr_rdata;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Request fields are captured at the handshake so the requester may move on
    always_ff @(posedge clk) begin
        if (ins_hs) begin
            funct3_q   <= bus.ins_funct3;
            addr_q     <= bus.ins_addr;
            src_q      <= bus.ins_src;
            zimm_q     <= bus.ins_zimm;
            src_zero_q <= bus.ins_src_zero;
        end
        if (trap_hs) begin
            cause_q <= bus.trap_cause;
            pc_q    <= bus.trap_pc[31:2];
        end
        if (state == RD) begin
            old_q <= rd_val;
        end
    end

    always_comb begin
        state_nxt       = state;
        bus.rsp_valid   = 1'b0;
        bus.rsp_rdata   = '0;
        bus.rsp_illegal = 1'b0;
        bus.redir_valid = 1'b0;
        bus.redir_pc    = '0;
        csr_r_en        = 1'b0;
        csr_addr        = '0;
        csr_w_en        = 1'b0;
        csr_w_addr      = '0;
        csr_w_data      = '0;
        if (rstn) begin
            case (state)
                IDLE: begin
                    if (trap_hs) begin
                        state_nxt = bus.trap_is_mret ? M_EPC : T_EPC;
                    end else if (ins_hs) begin
                        state_nxt = (bus.ins_funct3[1:0] == 2'b00) ? WR : RD;
                    end
                end
                RD: begin
                    csr_r_en  = !cnt_rd;
                    csr_addr  = addr_q;
                    state_nxt = WR;
                end
                WR: begin
                    bus.rsp_valid   = 1'b1;
                    bus.rsp_illegal = illegal;
                    bus.rsp_rdata   = illegal ? 32'd0 : old_q;
                    if (wr_ok && !cnt_rd) begin
                        csr_w_en   = 1'b1;
                        csr_w_addr = addr_q;
                        csr_w_data = new_val;
                    end
                    state_nxt = IDLE;
                end
                T_EPC: begin
                    csr_w_en   = 1'b1;
                    csr_w_addr = MEPC_ADDR;
                    csr_w_data = {pc_q, 2'b00};
                    state_nxt  = T_CAUSE;
                end
                T_CAUSE: begin
                    csr_w_en   = 1'b1;
                    csr_w_addr = MCAUSE_ADDR;
                    csr_w_data = cause_q;
                    state_nxt  = T_VEC;
                end
                T_VEC: begin
                    csr_r_en        = 1'b1;
                    csr_addr        = MTVEC_ADDR;
                    bus.redir_valid = 1'b1;
                    bus.redir_pc    = {csr_rdata[31:2], 2'b00};
                    state_nxt       = IDLE;
                end
                M_EPC: begin
                    csr_r_en        = 1'b1;
                    csr_addr        = MEPC_ADDR;
                    bus.redir_valid = 1'b1;
                    bus.redir_pc    = csr_rdata;
                    state_nxt       = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Scoreboard bench for csr_access_ctrl: drivers push expected responses, writes and redirects;
// a monitor pops and compares whenever the DUT strobes one of them.
module tb_csr_access_ctrl;

    typedef struct packed {
        int          cyc;
        logic [11:0] addr;
        logic [31:0] data;
        logic        flag;
        logic        dc;
    } exp_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    csr_access_ctrl_if bus();

    logic        csr_r_en, csr_w_en;
    logic [11:0] csr_addr, csr_w_addr;
    logic [31:0] csr_rdata, csr_w_data;

    csr_access_ctrl dut (
        .clk        (clk),
        .rstn       (rstn),
        .bus        (bus),
        .csr_r_en   (csr_r_en),
        .csr_addr   (csr_addr),
        .csr_rdata  (csr_rdata),
        .csr_w_en   (csr_w_en),
        .csr_w_addr (csr_w_addr),
        .csr_w_data (csr_w_data)
    );

    // CSR file model: combinational read, write on clk, preloaded on the first edge
    logic [31:0] mem [0:4095];
    logic        mem_init = 1'b0;
    assign csr_rdata = mem[csr_addr];
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 32'd0;
            mem[12'h305] <= 32'h0000_0081;
            mem[12'hC01] <= 32'h0000_0055;
            mem_init     <= 1'b1;
        end else if (csr_w_en) begin
            mem[csr_w_addr] <= csr_w_data;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t rsp_q[$];
    exp_t wr_q[$];
    exp_t redir_q[$];
    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0) begin
                tests++;
                if (rsp_q.size() == 0) begin
                    fails++;
                    $display("FAIL rsp_unexpected: got rdata=%h illegal=%b at cyc %0d, required no response",
                             bus.rsp_rdata, bus.rsp_illegal, cyc);
                end else begin
                    e = rsp_q.pop_front();
                    if (cyc != e.cyc || bus.rsp_illegal !== e.flag || (!e.dc && bus.rsp_rdata !== e.data)) begin
                        fails++;
                        $display("FAIL rsp: got rdata=%h illegal=%b cyc=%0d, required rdata=%h illegal=%b cyc=%0d",
                                 bus.rsp_rdata, bus.rsp_illegal, cyc, e.data, e.flag, e.cyc);
                    end
                end
            end
            if (csr_w_en !== 1'b0) begin
                tests++;
                if (wr_q.size() == 0) begin
                    fails++;
                    $display("FAIL write_unexpected: got addr=%h data=%h at cyc %0d, required no write",
                             csr_w_addr, csr_w_data, cyc);
                end else begin
                    e = wr_q.pop_front();
                    if (cyc != e.cyc || csr_w_addr !== e.addr || csr_w_data !== e.data) begin
                        fails++;
                        $display("FAIL write: got addr=%h data=%h cyc=%0d, required addr=%h data=%h cyc=%0d",
                                 csr_w_addr, csr_w_data, cyc, e.addr, e.data, e.cyc);
                    end
                end
            end
            if (bus.redir_valid !== 1'b0) begin
                tests++;
                if (redir_q.size() == 0) begin
                    fails++;
                    $display("FAIL redir_unexpected: got pc=%h at cyc %0d, required no redirect", bus.redir_pc, cyc);
                end else begin
                    e = redir_q.pop_front();
                    if (cyc != e.cyc || bus.redir_pc !== e.data) begin
                        fails++;
                        $display("FAIL redir: got pc=%h cyc=%0d, required pc=%h cyc=%0d",
                                 bus.redir_pc, cyc, e.data, e.cyc);
                    end
                end
            end
        end
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after the handshake
    task automatic ins_req(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] s,
                           input logic [4:0] z, input logic sz,
                           input logic [31:0] exp_rd, input logic exp_ill, input logic exp_dc,
                           input logic exp_wr, input logic [31:0] exp_wd, output int n);
        exp_t e;
        int lat;
        bus.ins_funct3 = f3;  bus.ins_addr = a;  bus.ins_src = s;
        bus.ins_zimm = z;     bus.ins_src_zero = sz;
        bus.ins_valid = 1'b1;
        n = -1;
        for (int i = 0; i < 40 && n < 0; i++) begin
            @(negedge clk);
            if (bus.ins_ready === 1'b1) n = cyc;
            else begin @(posedge clk); #1; end
        end
        if (n < 0) begin
            tests++; fails++;
            $display("FAIL ins_handshake: got no ins_ready within 40 cycles, required acceptance");
            bus.ins_valid = 1'b0;
        end else begin
            lat = (f3[1:0] == 2'b00) ? 1 : 2;
            e.cyc = n + lat; e.addr = a; e.data = exp_rd; e.flag = exp_ill; e.dc = exp_dc;
            rsp_q.push_back(e);
            if (exp_wr) begin
                e.data = exp_wd; e.flag = 1'b0; e.dc = 1'b0;
                wr_q.push_back(e);
            end
            @(posedge clk); #1;
            bus.ins_valid = 1'b0;
            bus.ins_funct3 = ~f3;  bus.ins_addr = ~a;  bus.ins_src = ~s;
            bus.ins_zimm = ~z;     bus.ins_src_zero = ~sz;
        end
    endtask

    task automatic trap_req(input logic mret, input logic [31:0] cause, input logic [31:0] pc,
                            input logic full, input logic [31:0] exp_pc, output int n);
        exp_t e;
        bus.trap_is_mret = mret; bus.trap_cause = cause; bus.trap_pc = pc;
        bus.trap_valid = 1'b1;
        n = -1;
        for (int i = 0; i < 40 && n < 0; i++) begin
            @(negedge clk);
            if (bus.trap_ready === 1'b1) n = cyc;
            else begin @(posedge clk); #1; end
        end
        if (n < 0) begin
            tests++; fails++;
            $display("FAIL trap_handshake: got no trap_ready within 40 cycles, required acceptance");
            bus.trap_valid = 1'b0;
        end else begin
            e.flag = 1'b0; e.dc = 1'b0;
            if (mret) begin
                e.cyc = n + 1; e.addr = 12'h341; e.data = exp_pc;
                redir_q.push_back(e);
            end else begin
                e.cyc = n + 1; e.addr = 12'h341; e.data = {pc[31:2], 2'b00};
                wr_q.push_back(e);
                if (full) begin
                    e.cyc = n + 2; e.addr = 12'h342; e.data = cause;
                    wr_q.push_back(e);
                    e.cyc = n + 3; e.addr = 12'h305; e.data = exp_pc;
                    redir_q.push_back(e);
                end
            end
            @(posedge clk); #1;
            bus.trap_valid = 1'b0;
            bus.trap_is_mret = ~mret; bus.trap_cause = ~cause; bus.trap_pc = ~pc;
        end
    endtask

    initial begin
        int n, n_trap, n_ins;
        bus.ins_valid = 1'b0; bus.ins_funct3 = '0; bus.ins_addr = '0; bus.ins_src = '0;
        bus.ins_zimm = '0; bus.ins_src_zero = 1'b0;
        bus.trap_valid = 1'b0; bus.trap_is_mret = 1'b0; bus.trap_cause = '0; bus.trap_pc = '0;
        fork
            monitor();
            begin
                #200000;
                $display("FAIL watchdog: got no completion by 200000 ns, required finish");
                $fatal(1, "watchdog expired");
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        bus.ins_valid = 1'b1; bus.trap_valid = 1'b1;
        #1;
        chk("ins_ready_in_reset", {31'b0, bus.ins_ready}, 32'd0);
        chk("trap_ready_in_reset", {31'b0, bus.trap_ready}, 32'd0);
        bus.ins_valid = 1'b0; bus.trap_valid = 1'b0;
        rstn = 1'b1;
        #1;
        chk("ins_ready_idle", {31'b0, bus.ins_ready}, 32'd1);
        chk("trap_ready_idle", {31'b0, bus.trap_ready}, 32'd1);
        chk("rsp_valid_idle", {31'b0, bus.rsp_valid}, 32'd0);
        chk("redir_valid_idle", {31'b0, bus.redir_valid}, 32'd0);
        chk("csr_w_en_idle", {31'b0, csr_w_en}, 32'd0);
        chk("csr_r_en_idle", {31'b0, csr_r_en}, 32'd0);
        @(posedge clk); #1;

        // funct3, addr, src, zimm, src_zero, rdata, illegal, dc, write, wdata
        ins_req(3'b001, 12'h300, 32'h1234_5678, 5'd0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h1234_5678, n);
        ins_req(3'b010, 12'h300, 32'h0000_FFFF, 5'd0, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 32'h0,         n);
        ins_req(3'b010, 12'h300, 32'h0000_00F0, 5'd0, 1'b0, 32'h1234_5678, 1'b0, 1'b0, 1'b1, 32'h1234_56F8, n);
        ins_req(3'b011, 12'h300, 32'h0000_0078, 5'd0, 1'b0, 32'h1234_56F8, 1'b0, 1'b0, 1'b1, 32'h1234_5680, n);
        ins_req(3'b101, 12'h301, 32'hDEAD_BEEF, 5'h1F, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0000_001F, n);
        ins_req(3'b110, 12'h301, 32'hFFFF_FFFF, 5'd0, 1'b0, 32'h1F,        1'b0, 1'b0, 1'b0, 32'h0,         n);
        ins_req(3'b111, 12'h301, 32'hFFFF_FFFF, 5'd3, 1'b1, 32'h1F,        1'b0, 1'b0, 1'b1, 32'h0000_001C, n);

        fork
            trap_req(1'b0, 32'h0000_000B, 32'h0000_0106, 1'b1, 32'h0000_0080, n_trap);
            ins_req(3'b010, 12'h342, 32'h0, 5'd0, 1'b1, 32'h0000_000B, 1'b0, 1'b0, 1'b0, 32'h0, n_ins);
        join
        chk("ins_after_trap_cycle", n_ins, n_trap + 4);

        ins_req(3'b001, 12'h341, 32'h0000_0200, 5'd0, 1'b0, 32'h0000_0104, 1'b0, 1'b0, 1'b1, 32'h0000_0200, n);
        trap_req(1'b1, 32'h0, 32'h0, 1'b1, 32'h0000_0200, n);

        ins_req(3'b000, 12'h300, 32'h1, 5'd1, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'h0, n);
        ins_req(3'b100, 12'h300, 32'h1, 5'd1, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'h0, n);
        ins_req(3'b001, 12'hC01, 32'h5, 5'd0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'h0, n);
        ins_req(3'b010, 12'hC01, 32'h5, 5'd0, 1'b1, 32'h55, 1'b0, 1'b0, 1'b0, 32'h0, n);
        ins_req(3'b110, 12'hC01, 32'h0, 5'd0, 1'b0, 32'h55, 1'b0, 1'b0, 1'b0, 32'h0, n);
        ins_req(3'b111, 12'hC01, 32'h0, 5'd1, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'h0, n);

        // Reset lands while the mcause write is pending: only mepc is expected
        trap_req(1'b0, 32'h0000_0007, 32'h0000_0300, 1'b0, 32'h0, n);
        @(posedge clk); #1;
        rstn = 1'b0;
        #1;
        chk("w_en_gated_in_reset", {31'b0, csr_w_en}, 32'd0);
        chk("redir_gated_in_reset", {31'b0, bus.redir_valid}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        chk("mcause_after_reset", mem[12'h342], 32'h0000_000B);
        chk("mepc_after_reset", mem[12'h341], 32'h0000_0300);
        repeat (5) @(posedge clk);
        #1;
        ins_req(3'b010, 12'h342, 32'h0, 5'd0, 1'b1, 32'h0000_000B, 1'b0, 1'b0, 1'b0, 32'h0, n);

`ifdef CSR_COUNTER_EN
        ins_req(3'b001, 12'hB00, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, n);
        repeat (11) @(posedge clk);
        #1;
        ins_req(3'b010, 12'hC00, 32'h0, 5'd0, 1'b1, 32'd10, 1'b0, 1'b0, 1'b0, 32'h0, n);
`endif

        repeat (10) @(posedge clk);
        #1;
        chk("rsp_queue_drained", rsp_q.size(), 32'd0);
        chk("write_queue_drained", wr_q.size(), 32'd0);
        chk("redir_queue_drained", redir_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
